// File: rtl/letc_core_fetch.sv
// Instruction fetch: one outstanding imem request feeding a 2-entry queue to decode.
// Redirects flush the queue and drop any in-flight response; decode backpressure throttles requests.
module letc_core_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_req_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  input  logic        i_imem_rsp_fault,
  output logic        o_dec_valid,
  input  logic        i_dec_ready,
  output logic [31:0] o_dec_instr,
  output logic [31:0] o_dec_pc,
  output logic        o_dec_fault,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DISCARD} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_req_pc;
  logic [31:0] r_q_instr [2];
  logic [31:0] r_q_pc    [2];
  logic [1:0]  r_q_fault;
  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic [1:0]  r_count;
  logic        w_req_hs;
  logic        w_push;
  logic        w_pop;

  // Only request when a response is guaranteed a free slot.
  assign o_imem_req_valid = !i_rst && (r_state == S_REQ) && (r_count <= 2'd1) && !i_redirect_valid;
  assign o_imem_req_addr  = {r_pc[31:2], 2'b00};
  assign w_req_hs         = o_imem_req_valid && i_imem_req_ready;

  assign o_dec_valid = !i_rst && (r_count != 2'd0);
  assign o_dec_instr = r_q_instr[r_rd_ptr];
  assign o_dec_pc    = r_q_pc[r_rd_ptr];
  assign o_dec_fault = r_q_fault[r_rd_ptr];

  assign w_push = (r_state == S_WAIT) && i_imem_rsp_valid && !i_redirect_valid;
  assign w_pop  = o_dec_valid && i_dec_ready && !i_redirect_valid;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_REQ:     if (w_req_hs) w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (i_imem_rsp_valid)      w_state_nxt = S_REQ;
        else if (i_redirect_valid) w_state_nxt = S_DISCARD;
      end
      // A response landing together with a redirect still retires the old request.
      S_DISCARD: if (i_imem_rsp_valid) w_state_nxt = S_REQ;
      default:   w_state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_REQ;
      r_pc     <= RESET_PC;
      r_req_pc <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      if (i_redirect_valid) begin
        r_pc <= i_redirect_pc;
      end else if (w_req_hs) begin
        r_pc     <= o_imem_req_addr + 32'd4;
        r_req_pc <= o_imem_req_addr;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_redirect_valid) begin
      r_count  <= 2'd0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_q_instr[r_wr_ptr] <= i_imem_rsp_data;
      r_q_pc[r_wr_ptr]    <= r_req_pc;
      r_q_fault[r_wr_ptr] <= i_imem_rsp_fault;
    end
  end

  a_no_rsp_in_req: assert property (@(posedge i_clk) disable iff (i_rst)
    !((r_state == S_REQ) && i_imem_rsp_valid));

endmodule

// File: tb/tb_letc_core_fetch.sv
// Scoreboarded bench for letc_core_fetch: directed scenarios, auto-responding memory model,
// and a decode-side monitor that pops expected entries on every accepted instruction.
module tb_letc_core_fetch;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        o_imem_req_valid;
  logic        i_imem_req_ready = 1'b0;
  logic [31:0] o_imem_req_addr;
  logic        i_imem_rsp_valid;
  logic [31:0] i_imem_rsp_data;
  logic        i_imem_rsp_fault;
  logic        o_dec_valid;
  logic        i_dec_ready = 1'b0;
  logic [31:0] o_dec_instr;
  logic [31:0] o_dec_pc;
  logic        o_dec_fault;
  logic        i_redirect_valid = 1'b0;
  logic [31:0] i_redirect_pc = 32'h0;

  logic        m_rsp_valid = 1'b0;
  logic [31:0] m_rsp_data  = 32'h0;
  logic        m_rsp_fault = 1'b0;
  logic        t_rsp_valid = 1'b0;
  logic [31:0] t_rsp_data  = 32'h0;

  assign i_imem_rsp_valid = m_rsp_valid | t_rsp_valid;
  assign i_imem_rsp_data  = t_rsp_valid ? t_rsp_data : m_rsp_data;
  assign i_imem_rsp_fault = t_rsp_valid ? 1'b0 : m_rsp_fault;

  // second instance exercising the wrap from the top of the address space
  logic        i2_rst = 1'b1;
  logic        i2_req_ready = 1'b0;
  logic        i2_rsp_valid = 1'b0;
  logic [31:0] i2_rsp_data = 32'h0;
  logic        o2_req_valid;
  logic [31:0] o2_req_addr;
  logic        o2_dec_valid;
  logic [31:0] o2_dec_instr;
  logic [31:0] o2_dec_pc;
  logic        o2_dec_fault;

  int          n_run  = 0;
  int          n_fail = 0;
  exp_t        exp_q[$];

  int          rsp_lat    = 1;
  int          rsp_cnt    = 0;
  int          rsp_limit  = 0;
  int          hs_cnt     = 0;
  logic [31:0] mem_base   = 32'h0;
  logic        mem_mix    = 1'b0;
  logic [31:0] fault_addr = 32'hFFFF_FFF0;

  letc_core_fetch u_dut (
    .i_clk            (clk),
    .i_rst            (i_rst),
    .o_imem_req_valid (o_imem_req_valid),
    .i_imem_req_ready (i_imem_req_ready),
    .o_imem_req_addr  (o_imem_req_addr),
    .i_imem_rsp_valid (i_imem_rsp_valid),
    .i_imem_rsp_data  (i_imem_rsp_data),
    .i_imem_rsp_fault (i_imem_rsp_fault),
    .o_dec_valid      (o_dec_valid),
    .i_dec_ready      (i_dec_ready),
    .o_dec_instr      (o_dec_instr),
    .o_dec_pc         (o_dec_pc),
    .o_dec_fault      (o_dec_fault),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc)
  );

  letc_core_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut2 (
    .i_clk            (clk),
    .i_rst            (i2_rst),
    .o_imem_req_valid (o2_req_valid),
    .i_imem_req_ready (i2_req_ready),
    .o_imem_req_addr  (o2_req_addr),
    .i_imem_rsp_valid (i2_rsp_valid),
    .i_imem_rsp_data  (i2_rsp_data),
    .i_imem_rsp_fault (1'b0),
    .o_dec_valid      (o2_dec_valid),
    .i_dec_ready      (1'b0),
    .o_dec_instr      (o2_dec_instr),
    .o_dec_pc         (o2_dec_pc),
    .o_dec_fault      (o2_dec_fault),
    .i_redirect_valid (1'b0),
    .i_redirect_pc    (32'h0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory model: answers up to rsp_limit requests, rsp_lat cycles after the handshake
  initial begin : mem_model
    logic [31:0] a;
    forever begin
      @(negedge clk);
      if (!i_rst && o_imem_req_valid && i_imem_req_ready) begin
        hs_cnt++;
        if (rsp_cnt < rsp_limit) begin
          rsp_cnt++;
          a = o_imem_req_addr;
          @(posedge clk);
          repeat (rsp_lat - 1) @(posedge clk);
          #1;
          m_rsp_valid = 1'b1;
          m_rsp_data  = mem_mix ? (mem_base | a) : mem_base;
          m_rsp_fault = (a == fault_addr);
          @(posedge clk);
          #1;
          m_rsp_valid = 1'b0;
          m_rsp_fault = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!i_rst && !i_redirect_valid && o_dec_valid && i_dec_ready) begin
      if (exp_q.size() == 0) begin
        chk("dec_unexpected_pc", o_dec_pc, 32'hxxxx_xxxx);
      end else begin
        e = exp_q.pop_front();
        chk("dec_instr", o_dec_instr, e.instr);
        chk("dec_pc", o_dec_pc, e.pc);
        chk("dec_fault", {31'b0, o_dec_fault}, {31'b0, e.fault});
      end
    end
  end

  task automatic push_exp(input logic [31:0] instr, input logic [31:0] pc, input logic fault);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    e.fault = fault;
    exp_q.push_back(e);
  endtask

  task automatic hold_reset();
    @(posedge clk);
    #1;
    i_rst            = 1'b1;
    i_redirect_valid = 1'b0;
    t_rsp_valid      = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    i_rst = 1'b0;
  endtask

  task automatic drain(input string name, input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk(name, exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int hs0;
    // reset values and basic streaming with 2-cycle memory latency
    i_imem_req_ready = 1'b1;
    i_dec_ready      = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", {31'b0, o_imem_req_valid}, 32'd0);
    chk("rst_dec_valid", {31'b0, o_dec_valid}, 32'd0);
    rsp_lat   = 2;
    mem_base  = 32'h0000_0013;
    mem_mix   = 1'b0;
    rsp_limit = rsp_cnt + 3;
    push_exp(32'h0000_0013, 32'h0, 1'b0);
    push_exp(32'h0000_0013, 32'h4, 1'b0);
    push_exp(32'h0000_0013, 32'h8, 1'b0);
    release_reset();
    @(negedge clk);
    chk("first_req_valid", {31'b0, o_imem_req_valid}, 32'd1);
    chk("first_req_addr", o_imem_req_addr, 32'h0);
    drain("stream_drain", 60);

    // decode stalled: two entries fill, then requests stop
    hold_reset();
    i_dec_ready = 1'b0;
    rsp_lat     = 1;
    mem_base    = 32'hA5A5_0000;
    mem_mix     = 1'b1;
    rsp_limit   = rsp_cnt + 3;
    hs0         = hs_cnt;
    release_reset();
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("full_hs_cnt", hs_cnt - hs0, 2);
    chk("full_req_valid", {31'b0, o_imem_req_valid}, 32'd0);
    chk("full_dec_valid", {31'b0, o_dec_valid}, 32'd1);
    chk("full_head_pc", o_dec_pc, 32'h0);
    push_exp(32'hA5A5_0000, 32'h0, 1'b0);
    push_exp(32'hA5A5_0004, 32'h4, 1'b0);
    push_exp(32'hA5A5_0008, 32'h8, 1'b0);
    i_dec_ready = 1'b1;
    drain("full_drain", 40);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("full_hs_after_pop", hs_cnt - hs0, 4);

    // redirect while waiting; the late response must be discarded
    hold_reset();
    rsp_limit = rsp_cnt;
    release_reset();
    @(posedge clk);
    #1;
    i_redirect_valid = 1'b1;
    i_redirect_pc    = 32'h8000_0000;
    @(posedge clk);
    #1;
    i_redirect_valid = 1'b0;
    t_rsp_valid      = 1'b1;
    t_rsp_data       = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("discard_req_valid", {31'b0, o_imem_req_valid}, 32'd0);
    @(posedge clk);
    #1;
    t_rsp_valid = 1'b0;
    @(negedge clk);
    chk("redir_req_valid", {31'b0, o_imem_req_valid}, 32'd1);
    chk("redir_req_addr", o_imem_req_addr, 32'h8000_0000);
    chk("redir_dec_valid", {31'b0, o_dec_valid}, 32'd0);

    // redirect in the same cycle as the response
    hold_reset();
    rsp_limit = rsp_cnt;
    release_reset();
    @(posedge clk);
    #1;
    t_rsp_valid      = 1'b1;
    t_rsp_data       = 32'h1111_1111;
    i_redirect_valid = 1'b1;
    i_redirect_pc    = 32'h0000_0100;
    @(posedge clk);
    #1;
    t_rsp_valid      = 1'b0;
    i_redirect_valid = 1'b0;
    mem_base         = 32'h2222_0000;
    mem_mix          = 1'b1;
    rsp_lat          = 1;
    rsp_limit        = rsp_cnt + 1;
    push_exp(32'h2222_0100, 32'h100, 1'b0);
    @(negedge clk);
    chk("same_req_valid", {31'b0, o_imem_req_valid}, 32'd1);
    chk("same_req_addr", o_imem_req_addr, 32'h0000_0100);
    chk("same_dec_valid", {31'b0, o_dec_valid}, 32'd0);
    drain("same_drain", 20);

    // faulting response is queued and fetching continues
    hold_reset();
    mem_base   = 32'hC0DE_0000;
    mem_mix    = 1'b1;
    rsp_lat    = 1;
    fault_addr = 32'h0000_0010;
    rsp_limit  = rsp_cnt + 6;
    for (int i = 0; i < 6; i++)
      push_exp(32'hC0DE_0000 | (i * 4), i * 4, (i == 4));
    release_reset();
    drain("fault_drain", 60);

    // RESET_PC at the top of the address space wraps to zero
    @(negedge clk);
    chk("wrap_rst_valid", {31'b0, o2_req_valid}, 32'd0);
    @(posedge clk);
    #1;
    i2_rst = 1'b0;
    @(negedge clk);
    chk("wrap_first_valid", {31'b0, o2_req_valid}, 32'd1);
    chk("wrap_first_addr", o2_req_addr, 32'hFFFF_FFFC);
    @(posedge clk);
    #1;
    i2_req_ready = 1'b1;
    @(posedge clk);
    #1;
    i2_req_ready = 1'b0;
    i2_rsp_valid = 1'b1;
    i2_rsp_data  = 32'h0000_0013;
    @(posedge clk);
    #1;
    i2_rsp_valid = 1'b0;
    @(negedge clk);
    chk("wrap_second_valid", {31'b0, o2_req_valid}, 32'd1);
    chk("wrap_second_addr", o2_req_addr, 32'h0000_0000);
    chk("wrap_dec_pc", o2_dec_pc, 32'hFFFF_FFFC);
    chk("wrap_dec_instr", o2_dec_instr, 32'h0000_0013);
    chk("wrap_dec_fault", {31'b0, o2_dec_fault}, 32'd0);
    chk("wrap_dec_valid", {31'b0, o2_dec_valid}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/letc_core_fetch.md
LETC_CORE_FETCH -- requirements
Module: letc_core_fetch

Interface
REQ-001 The module SHALL take parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The module SHALL have port i_clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port i_rst  in  1  reset, synchronous and active-high.
REQ-004 The module SHALL have port o_imem_req_valid  out  1  fetch request valid.
REQ-005 The module SHALL have port i_imem_req_ready  in  1  memory accepts request.
REQ-006 The module SHALL have port o_imem_req_addr  out  32  word-aligned fetch address.
REQ-007 The module SHALL have port i_imem_rsp_valid  in  1  response valid, single cycle, no backpressure.
REQ-008 The module SHALL have port i_imem_rsp_data  in  32  fetched instruction word (word_t).
REQ-009 The module SHALL have port i_imem_rsp_fault  in  1  access fault on this response.
REQ-010 The module SHALL have port o_dec_valid  out  1  instruction valid to decode.
REQ-011 The module SHALL have port i_dec_ready  in  1  decode accepts instruction.
REQ-012 The module SHALL have ports o_dec_instr  out  32, o_dec_pc  out  32 and o_dec_fault  out  1: FIFO head word, its address, its fault flag.
REQ-013 The module SHALL have ports i_redirect_valid  in  1 and i_redirect_pc  in  32: branch/trap redirect.

Function
REQ-014 The fetch PC SHALL be a 32-bit register; o_imem_req_addr equals it with bits [1:0] forced to 0.
REQ-015 PC SHALL increment by 4 on each request handshake (valid & ready), wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-016 The state machine SHALL have states REQ, WAIT, DISCARD; at most one request outstanding.
REQ-017 In REQ, o_imem_req_valid SHALL be 1 iff FIFO count (registered, before this cycle's pop) <= 1 and no redirect this cycle; on handshake -> WAIT.
REQ-018 Address SHALL stay stable while o_imem_req_valid is 1 and ready is 0.
REQ-019 In WAIT, rsp_valid SHALL push {rsp_data, request PC, rsp_fault} into the FIFO and -> REQ; responses arrive no earlier than one cycle after handshake.
REQ-020 The FIFO SHALL be 2 entries; o_dec_valid = (count != 0); pop on o_dec_valid & i_dec_ready; push and pop in the same cycle keep count unchanged.
REQ-021 Redirect SHALL have highest priority: FIFO flushed (count := 0), PC := i_redirect_pc, any same-cycle decode pop ignored.
REQ-022 Redirect in REQ SHALL stay REQ; redirect in WAIT without rsp_valid SHALL -> DISCARD; redirect in WAIT with rsp_valid SHALL drop the response and -> REQ.
REQ-023 In DISCARD, rsp_valid SHALL be dropped and -> REQ; redirect in DISCARD updates PC and stays DISCARD.
REQ-024 A faulting response SHALL be queued normally (instr word passed as-is); fetching continues.
REQ-025 rsp_valid in REQ SHALL be ignored (protocol violation, flagged by assertion).

Reset
REQ-026 With i_rst high at a clock edge: state := REQ, PC := RESET_PC, FIFO count := 0.
REQ-027 Outputs SHALL read o_imem_req_valid=0 and o_dec_valid=0 while i_rst is high; o_imem_req_valid=1 with addr RESET_PC in the first cycle after i_rst falls.
REQ-028 Reset mid-operation SHALL abandon any outstanding request; a late response SHALL be handled as in REQ-025.

Verification
REQ-029 Reset release, ready=1, response 2 cycles after each handshake with data 32'h0000_0013 -> decode sees PCs 0x0,0x4,0x8 in order, o_dec_fault=0.
REQ-030 i_dec_ready=0 with memory always responding -> exactly 2 entries queued, o_imem_req_valid drops to 0, no third request until a pop.
REQ-031 Redirect to 0x8000_0000 while WAIT, response arrives next cycle -> that response dropped, next request addr 0x8000_0000, FIFO empty.
REQ-032 Redirect same cycle as rsp_valid in WAIT -> response dropped, state REQ, next addr = redirect PC.
REQ-033 RESET_PC=32'hFFFF_FFFC -> requests at 0xFFFF_FFFC then 0x0000_0000.
REQ-034 Response with i_imem_rsp_fault=1 at PC 0x10 -> entry presented with o_dec_fault=1, o_dec_pc=0x10, next fetch 0x14.
